shift_counter: RTL and testbench

Parametrised synchronous shift counter that runs as a one-hot ring counter or a Johnson (twisted-ring) counter, selectable at run time. It adds enable, direction, parallel load, illegal-state self-correction, a binary position output and a wrap pulse. It is the general-purpose successor for sequencer and phase-generator uses in the counters library.

---
 rtl/shift_counter_pkg.sv | 36 +++
 rtl/shift_counter_decode.sv | 43 ++++
 rtl/shift_counter.sv | 114 +++++++++++
 tb/tb_shift_counter.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/shift_counter_pkg.sv
// Shared types and helpers for the ring/Johnson shift counter.
package shift_counter_pkg;

  localparam int MAX_N = 64;

  localparam logic MODE_RING    = 1'b0;
  localparam logic MODE_JOHNSON = 1'b1;

  typedef logic [MAX_N-1:0] vec_t;

  // Next-cycle action chosen by the priority mux below clear.
  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_LOAD,
    ACT_SWITCH,
    ACT_FIX,
    ACT_SHIFT
  } act_e;

  // Ring restarts from bit 0 set; Johnson restarts from all zeros.
  function automatic vec_t start_pattern(input logic mode, input int n);
    vec_t mask;
    mask = (n >= MAX_N) ? '1 : ((vec_t'(1) << n) - vec_t'(1));
    return (mode == MODE_RING) ? (vec_t'(1) & mask) : '0;
  endfunction

  function automatic int unsigned popcount(input vec_t v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < MAX_N; i++) begin
      c += int'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/shift_counter_decode.sv
// Combinational legality check and sequence position for a counter pattern.
module shift_counter_decode
  import shift_counter_pkg::*;
#(
  parameter  int N  = 5,
  localparam int PW = $clog2(2*N)
) (
  input  logic [N-1:0]  q_i,
  input  logic          mode_i,
  output logic          legal_o,
  output logic [PW-1:0] pos_o
);

  int unsigned   pc;
  int            trans;
  logic [PW-1:0] ring_pos;

  always_comb begin
    pc       = popcount(vec_t'(q_i));
    trans    = 0;
    ring_pos = '0;
    // A Johnson state is a thermometer code: at most one 0/1 boundary.
    for (int i = 0; i < N-1; i++) begin
      trans += int'(q_i[i] ^ q_i[i+1]);
    end
    for (int i = N-1; i >= 0; i--) begin
      if (q_i[i]) ring_pos = PW'(i);
    end
  end

  always_comb begin
    legal_o = 1'b0;
    pos_o   = '0;
    if (mode_i == MODE_RING) begin
      legal_o = (pc == 1);
      pos_o   = ring_pos;
    end else begin
      legal_o = (trans <= 1);
      pos_o   = q_i[N-1] ? PW'(2*N - int'(pc)) : PW'(pc);
    end
  end

endmodule

// File: rtl/shift_counter.sv
// Run-time selectable ring / Johnson shift counter with load, direction,
// illegal-state self-correction, binary position and wrap pulse.
module shift_counter
  import shift_counter_pkg::*;
#(
  parameter  int N  = 5,
  localparam int PW = $clog2(2*N)
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          en,
  input  logic          dir,
  input  logic          mode,
  input  logic          load,
  input  logic [N-1:0]  load_val,
  output logic [N-1:0]  Q,
  output logic [PW-1:0] pos,
  output logic          wrap,
  output logic          err
);

  logic [N-1:0]  q_q, q_d;
  logic          mode_q, mode_d;
  logic          wrap_q, wrap_d;
  logic          err_q, err_d;
  act_e          act;

  logic [N-1:0]  start;
  logic [N-1:0]  fwd, rev;
  logic [PW-1:0] p_last;
  logic          q_legal, ld_legal;
  logic [PW-1:0] q_pos;
  logic [PW-1:0] ld_pos_unused;

  shift_counter_decode #(.N(N)) u_dec_q (
    .q_i     (q_q),
    .mode_i  (mode),
    .legal_o (q_legal),
    .pos_o   (q_pos)
  );

  shift_counter_decode #(.N(N)) u_dec_ld (
    .q_i     (load_val),
    .mode_i  (mode),
    .legal_o (ld_legal),
    .pos_o   (ld_pos_unused)
  );

  assign start  = N'(start_pattern(mode, N));
  assign p_last = (mode == MODE_JOHNSON) ? PW'(2*N - 1) : PW'(N - 1);
  assign fwd    = {q_q[N-2:0], (mode == MODE_JOHNSON) ? ~q_q[N-1] : q_q[N-1]};
  assign rev    = {(mode == MODE_JOHNSON) ? ~q_q[0] : q_q[0], q_q[N-1:1]};

  always_comb begin
    act = ACT_HOLD;
    if (load)                act = ACT_LOAD;
    else if (mode != mode_q) act = ACT_SWITCH;
    else if (!q_legal)       act = ACT_FIX;
    else if (en)             act = ACT_SHIFT;
  end

  always_comb begin
    q_d    = q_q;
    // A load is validated against the new mode, so it also absorbs a mode change.
    mode_d = mode;
    wrap_d = 1'b0;
    err_d  = 1'b0;
    case (act)
      ACT_LOAD: begin
        if (ld_legal) begin
          q_d = load_val;
        end else begin
          q_d   = start;
          err_d = 1'b1;
        end
      end
      ACT_SWITCH: q_d = start;
      ACT_FIX: begin
        q_d   = start;
        err_d = 1'b1;
      end
      ACT_SHIFT: begin
        if (!dir) begin
          q_d    = fwd;
          wrap_d = (q_pos == p_last);
        end else begin
          q_d    = rev;
          wrap_d = (q_pos == '0);
        end
      end
      default: q_d = q_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      q_q    <= start;
      mode_q <= mode;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      mode_q <= mode_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign Q    = q_q;
  assign pos  = q_pos;
  assign wrap = wrap_q;
  assign err  = err_q;

endmodule

// File: tb/tb_shift_counter.sv
// Scoreboard bench: directed vectors push expected state, a monitor pops and compares each cycle.
module tb_shift_counter;

  localparam int N  = 5;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          clear = 1'b1;
  logic          en = 1'b0;
  logic          dir = 1'b0;
  logic          mode = 1'b0;
  logic          load = 1'b0;
  logic [N-1:0]  load_val = '0;
  logic [N-1:0]  Q;
  logic [PW-1:0] pos;
  logic          wrap;
  logic          err;

  typedef struct packed {
    logic [N-1:0]  q;
    logic [PW-1:0] pos;
    logic          wrap;
    logic          err;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  shift_counter #(.N(N)) dut (
    .clk      (clk),
    .clear    (clear),
    .en       (en),
    .dir      (dir),
    .mode     (mode),
    .load     (load),
    .load_val (load_val),
    .Q        (Q),
    .pos      (pos),
    .wrap     (wrap),
    .err      (err)
  );

  task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s got %0h expected %0h", nm, fld, act, req);
    end
  endtask

  // Drive one cycle of inputs and record what the DUT must show after the next edge.
  task automatic step(input logic c, input logic l, input logic [N-1:0] lv,
                      input logic e, input logic d, input logic m,
                      input logic [N-1:0] xq, input logic [PW-1:0] xp,
                      input logic xw, input logic xe, input string nm);
    @(negedge clk);
    clear    = c;
    load     = l;
    load_val = lv;
    en       = e;
    dir      = d;
    mode     = m;
    exp_q.push_back({xq, xp, xw, xe});
    name_q.push_back(nm);
  endtask

  initial begin : monitor
    exp_t  e;
    string n;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        cmp(n, "Q",    32'(Q),    32'(e.q));
        cmp(n, "pos",  32'(pos),  32'(e.pos));
        cmp(n, "wrap", 32'(wrap), 32'(e.wrap));
        cmp(n, "err",  32'(err),  32'(e.err));
      end
    end
  end

  initial begin : watchdog
    #200000;
    errors++;
    $display("FAIL watchdog expired");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : stim
    //    clr ld lv        en dir m   Q         pos w  e
    step(1, 0, 5'b00000, 0, 0, 0, 5'b00001, 0, 0, 0, "rst0");
    step(1, 0, 5'b00000, 1, 0, 0, 5'b00001, 0, 0, 0, "rst1");
    // ring forward
    step(0, 0, 5'b00000, 1, 0, 0, 5'b00010, 1, 0, 0, "rf1");
    step(0, 0, 5'b00000, 1, 0, 0, 5'b00100, 2, 0, 0, "rf2");
    step(0, 0, 5'b00000, 1, 0, 0, 5'b01000, 3, 0, 0, "rf3");
    step(0, 0, 5'b00000, 1, 0, 0, 5'b10000, 4, 0, 0, "rf4");
    step(0, 0, 5'b00000, 1, 0, 0, 5'b00001, 0, 1, 0, "rf_wrap");
    step(0, 0, 5'b00000, 1, 0, 0, 5'b00010, 1, 0, 0, "rf5");
    step(0, 0, 5'b00000, 1, 0, 0, 5'b00100, 2, 0, 0, "rf6");
    // ring reverse then hold
    step(0, 0, 5'b00000, 1, 1, 0, 5'b00010, 1, 0, 0, "rr1");
    step(0, 0, 5'b00000, 1, 1, 0, 5'b00001, 0, 0, 0, "rr2");
    step(0, 0, 5'b00000, 1, 1, 0, 5'b10000, 4, 1, 0, "rr_wrap");
    step(0, 0, 5'b00000, 0, 1, 0, 5'b10000, 4, 0, 0, "rr_hold");
    // ring loads with en low
    step(0, 1, 5'b01000, 0, 0, 0, 5'b01000, 3, 0, 0, "ld_ok");
    step(0, 1, 5'b01010, 0, 0, 0, 5'b00001, 0, 0, 1, "ld_bad");
    step(0, 0, 5'b00000, 0, 0, 0, 5'b00001, 0, 0, 0, "ld_errclr");
    // upset: illegal state corrected even with en low
    @(negedge clk);
    force dut.q_q = 5'b00110;
    #1;
    release dut.q_q;
    exp_q.push_back({5'b00001, 4'd0, 1'b0, 1'b1});
    name_q.push_back("upset_fix");
    step(0, 0, 5'b00000, 0, 0, 0, 5'b00001, 0, 0, 0, "upset_after");
    // mode switch from ring 00100
    step(0, 0, 5'b00000, 1, 0, 0, 5'b00010, 1, 0, 0, "ms_a");
    step(0, 0, 5'b00000, 1, 0, 0, 5'b00100, 2, 0, 0, "ms_b");
    step(0, 0, 5'b00000, 1, 0, 1, 5'b00000, 0, 0, 0, "ms_switch");
    step(0, 0, 5'b00000, 1, 0, 1, 5'b00001, 1, 0, 0, "jf1");
    // Johnson forward
    step(0, 0, 5'b00000, 1, 0, 1, 5'b00011, 2, 0, 0, "jf2");
    step(0, 0, 5'b00000, 1, 0, 1, 5'b00111, 3, 0, 0, "jf3");
    step(0, 0, 5'b00000, 1, 0, 1, 5'b01111, 4, 0, 0, "jf4");
    step(0, 0, 5'b00000, 1, 0, 1, 5'b11111, 5, 0, 0, "jf5");
    step(0, 0, 5'b00000, 1, 0, 1, 5'b11110, 6, 0, 0, "jf6");
    step(0, 0, 5'b00000, 1, 0, 1, 5'b11100, 7, 0, 0, "jf7");
    step(0, 0, 5'b00000, 1, 0, 1, 5'b11000, 8, 0, 0, "jf8");
    step(0, 0, 5'b00000, 1, 0, 1, 5'b10000, 9, 0, 0, "jf9");
    step(0, 0, 5'b00000, 1, 0, 1, 5'b00000, 0, 1, 0, "jf_wrap");
    // Johnson wrap in both directions
    step(0, 0, 5'b00000, 1, 1, 1, 5'b10000, 9, 1, 0, "jr_wrap");
    step(0, 0, 5'b00000, 1, 0, 1, 5'b00000, 0, 1, 0, "jf_wrap2");
    // Johnson loads
    step(0, 1, 5'b00101, 0, 0, 1, 5'b00000, 0, 0, 1, "jld_bad");
    step(0, 1, 5'b11100, 0, 0, 1, 5'b11100, 7, 0, 0, "jld_ok");
    // clear beats load, en and mode change
    step(1, 1, 5'b00011, 1, 0, 1, 5'b00000, 0, 0, 0, "clr_j");
    step(0, 0, 5'b00000, 1, 0, 0, 5'b00001, 0, 0, 0, "ms_to_ring");
    step(0, 0, 5'b00000, 1, 0, 0, 5'b00010, 1, 0, 0, "rf7");
    step(0, 0, 5'b00000, 1, 0, 0, 5'b00100, 2, 0, 0, "rf8");
    step(1, 1, 5'b01000, 1, 0, 0, 5'b00001, 0, 0, 0, "clr_r");
    step(0, 0, 5'b00000, 0, 0, 0, 5'b00001, 0, 0, 0, "clr_r_hold");
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain left %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
